// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two core requesters, the arbiter and the word memory.
// slave is the arbiter's view; master is the requester/memory-model view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned DATA_W = 32;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rdata, d_ready, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one single-ported, fixed-latency word memory between
// instruction fetch and data access; fetch is held off while the core is halted.
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              halted,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    typedef struct packed {
        logic              fetch;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } access_t;

    state_t           state_q, state_d;
    access_t          acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_fetch_q, last_fetch_d;
    logic             capture;
    logic             elig_if;
    logic             elig_d;
    logic             pick_fetch;

    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_ready_q;
    logic              d_ready_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    // State register and latched access
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            last_fetch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            last_fetch_q <= last_fetch_d;
        end
    end

    // Next-state, grant selection and read-capture strobe
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        last_fetch_d = last_fetch_q;
        capture      = 1'b0;
        elig_if      = bus.if_req & ~halted;
        elig_d       = bus.d_req;
        // On conflict the requester that was not served last wins
        pick_fetch   = elig_if & (~elig_d | ~last_fetch_q);

        case (state_q)
            IDLE: begin
                if (elig_if | elig_d) begin
                    acc_d.fetch  = pick_fetch;
                    acc_d.we     = pick_fetch ? 1'b0 : bus.d_we;
                    acc_d.addr   = pick_fetch ? bus.if_addr : bus.d_addr;
                    acc_d.wdata  = pick_fetch ? acc_q.wdata : bus.d_wdata;
                    last_fetch_d = pick_fetch;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (acc_q.we) begin
                    state_d = DONE;
                end else if (LATENCY == 1) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            mem_en_q   <= (state_d == ISSUE);
            mem_we_q   <= (state_d == ISSUE) & acc_d.we;
            if_ready_q <= (state_d == DONE) & acc_d.fetch;
            d_ready_q  <= (state_d == DONE) & ~acc_d.fetch;
            if (state_d == ISSUE) begin
                mem_addr_q  <= acc_d.addr;
                mem_wdata_q <= acc_d.wdata;
            end
            if (capture) begin
                if (acc_q.fetch) begin
                    if_rdata_q <= bus.mem_rdata;
                end else begin
                    d_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic against a transaction-level timing model.
module tb_mem_port_arbiter;
    localparam int unsigned LAT = 2;
    localparam int unsigned AW  = 32;

    logic clk    = 1'b0;
    logic rst_b  = 1'b0;
    logic halted = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW)) bus();

    mem_port_arbiter #(.LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk    (clk),
        .rst_b  (rst_b),
        .halted (halted),
        .bus    (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Memory model: reads return data valid exactly LAT cycles after the strobe cycle
    logic [31:0] mem [logic [31:0]];
    logic [31:0] pd [LAT];
    logic        pv [LAT];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return ~a;
    endfunction

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < int'(LAT); i++) begin
                pv[i] <= 1'b0;
                pd[i] <= 32'h0;
            end
        end else begin
            if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            pd[0] <= mem_rd(bus.mem_addr);
            pv[0] <= bus.mem_en && !bus.mem_we;
            for (int i = 1; i < int'(LAT); i++) begin
                pd[i] <= pd[i-1];
                pv[i] <= pv[i-1];
            end
        end
    end

    assign bus.mem_rdata = pv[LAT-1] ? pd[LAT-1] : 32'hA5A5_A5A5;

    typedef struct {
        logic        if_req;
        logic        d_req;
        logic        d_we;
        logic        halted;
        logic [31:0] if_addr;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        int          exp_who;   // 0 none, 1 fetch, 2 data
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_rdata; // grantee's rdata after completion
    } vec_t;

    vec_t vecs [10];

    task automatic drop_all();
        bus.if_req  = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.if_addr = 32'h0;
        bus.d_addr  = 32'h0;
        bus.d_wdata = 32'h0;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        drop_all();
        halted = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int en_at = -1, rdy_at = -1, en_cnt = 0, f_rdy = 0, d_rdy = 0;
        logic [31:0] en_addr = 32'h0, en_wdata = 32'h0;
        logic en_we = 1'b0;
        string p = $sformatf("v%0d", idx);
        bus.if_req = v.if_req;  bus.if_addr = v.if_addr;
        bus.d_req  = v.d_req;   bus.d_we    = v.d_we;
        bus.d_addr = v.d_addr;  bus.d_wdata = v.d_wdata;
        halted     = v.halted;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (bus.mem_en) begin
                en_cnt++;
                if (en_at < 0) begin
                    en_at = k; en_addr = bus.mem_addr; en_we = bus.mem_we; en_wdata = bus.mem_wdata;
                end
            end
            if (bus.if_ready) f_rdy++;
            if (bus.d_ready)  d_rdy++;
            if (bus.if_ready || bus.d_ready) begin
                rdy_at = k;
                break;
            end
        end
        drop_all();
        halted = 1'b0;
        if (v.exp_who == 0) begin
            chk_i({p, " en_count"}, en_cnt, 0);
            chk_i({p, " ready_at"}, rdy_at, -1);
        end else begin
            chk_i({p, " en_count"}, en_cnt, 1);
            chk_i({p, " en_at"}, en_at, 1);
            chk({p, " mem_addr"}, en_addr, v.exp_addr);
            chk1({p, " mem_we"}, en_we, v.exp_we);
            if (v.exp_we) chk({p, " mem_wdata"}, en_wdata, v.d_wdata);
            chk_i({p, " ready_at"}, rdy_at, v.exp_we ? 2 : int'(LAT) + 2);
            chk_i({p, " if_ready"}, f_rdy, (v.exp_who == 1) ? 1 : 0);
            chk_i({p, " d_ready"}, d_rdy, (v.exp_who == 2) ? 1 : 0);
            chk({p, " rdata"}, (v.exp_who == 1) ? bus.if_rdata : bus.d_rdata, v.exp_rdata);
        end
        @(posedge clk); #1;
    endtask

    // Reference model state for randomized traffic
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return ~a;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h1000 + (32'($urandom_range(0, 7)) << 2);
    endfunction

    initial begin
        int en1, en2, first_who, n, cnt;
        logic [31:0] a1, a2;
        int order [6];
        int e_en, e_rdy, idle_at;
        logic e_f, e_we, last_f, f_busy, d_busy;
        logic [31:0] e_addr, e_wdata, e_rdval, m_if, m_d, m_addr;

        mem[32'h40] = 32'h8C22_0004;
        //            ifr   dr    dwe   halt  if_addr       d_addr        d_wdata       who exp_addr      we    exp_rdata
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0,        32'h0,        1, 32'h0000_0040, 1'b0, 32'h8C22_0004};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0000_0100, 32'h0,        2, 32'h0000_0100, 1'b0, 32'hFFFF_FEFF};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0048, 32'h0000_0104, 32'h1111_2222, 1, 32'h0000_0048, 1'b0, 32'hFFFF_FFB7};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0000_0200, 32'hDEAD_BEEF, 2, 32'h0000_0200, 1'b1, 32'hFFFF_FEFF};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_004C, 32'h0000_0200, 32'h0,        2, 32'h0000_0200, 1'b0, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0050, 32'h0,        32'h0,        0, 32'h0,        1'b0, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        0, 32'h0,        1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0300, 32'h0,        1, 32'h0000_0040, 1'b0, 32'h8C22_0004};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0054, 32'h0000_0040, 32'hCAFE_F00D, 2, 32'h0000_0040, 1'b1, 32'hDEAD_BEEF};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0,        32'h0,        1, 32'h0000_0040, 1'b0, 32'hCAFE_F00D};

        // Reset values, with requests already pending
        drop_all();
        bus.if_req = 1'b1;
        bus.d_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst mem_en", bus.mem_en, 1'b0);
        chk1("rst mem_we", bus.mem_we, 1'b0);
        chk1("rst if_ready", bus.if_ready, 1'b0);
        chk1("rst d_ready", bus.d_ready, 1'b0);
        chk("rst mem_addr", bus.mem_addr, 32'h0);
        chk("rst mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst if_rdata", bus.if_rdata, 32'h0);
        chk("rst d_rdata", bus.d_rdata, 32'h0);

        rst_b = 1'b1;
        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Conflict right after reset: fetch first, data strobe LAT+3 cycles later
        do_reset();
        bus.if_req = 1'b1; bus.if_addr = 32'h60;
        bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
        en1 = -1; en2 = -1; first_who = 0; a1 = 32'h0; a2 = 32'h0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (bus.mem_en) begin
                if (en1 < 0) begin en1 = k; a1 = bus.mem_addr; end
                else if (en2 < 0) begin en2 = k; a2 = bus.mem_addr; end
            end
            if (bus.if_ready) begin
                if (first_who == 0) first_who = 1;
                bus.if_req = 1'b0;
            end
            if (bus.d_ready) begin
                if (first_who == 0) first_who = 2;
                bus.d_req = 1'b0;
                break;
            end
        end
        drop_all();
        chk_i("conflict first", first_who, 1);
        chk("conflict addr1", a1, 32'h60);
        chk("conflict addr2", a2, 32'h100);
        chk_i("conflict gap", en2 - en1, int'(LAT) + 3);
        chk("conflict if_rdata", bus.if_rdata, 32'hFFFF_FF9F);
        chk("conflict d_rdata", bus.d_rdata, 32'hFFFF_FEFF);
        @(posedge clk); #1;

        // Round-robin under continuous contention
        bus.if_req = 1'b1; bus.if_addr = 32'h64;
        bus.d_req  = 1'b1; bus.d_addr = 32'h104;
        n = 0;
        for (int i = 0; i < 6; i++) order[i] = 0;
        for (int k = 1; k <= 60 && n < 6; k++) begin
            @(posedge clk); #1;
            if (bus.if_ready) begin order[n] = 1; n++; end
            else if (bus.d_ready) begin order[n] = 2; n++; end
        end
        drop_all();
        for (int i = 0; i < 6; i++) chk_i($sformatf("rr grant%0d", i), order[i], (i % 2 == 0) ? 1 : 2);
        @(posedge clk); #1;

        // Halt blocks fetch; data still served
        halted = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h70;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus.mem_en) cnt++;
        end
        chk_i("halt no_en", cnt, 0);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        en1 = -1; cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (bus.if_ready) cnt++;
            if (bus.d_ready) begin en1 = k; break; end
        end
        drop_all();
        halted = 1'b0;
        chk_i("halt d_ready_at", en1, int'(LAT) + 2);
        chk_i("halt if_ready", cnt, 0);
        chk("halt d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // Reset during WAIT abandons the access
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        @(posedge clk); #1;
        chk1("midrst issue", bus.mem_en, 1'b1);
        @(posedge clk); #1;
        rst_b = 1'b0;
        #1;
        chk1("midrst mem_en", bus.mem_en, 1'b0);
        chk("midrst mem_addr", bus.mem_addr, 32'h0);
        chk("midrst d_rdata", bus.d_rdata, 32'h0);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (bus.if_ready || bus.d_ready || bus.mem_en) cnt++;
        end
        chk_i("midrst quiet", cnt, 0);
        chk("midrst if_rdata", bus.if_rdata, 32'h0);
        rst_b = 1'b1;
        en1 = -1; en2 = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (bus.mem_en && en1 < 0) en1 = k;
            if (bus.if_ready) begin en2 = k; break; end
        end
        drop_all();
        chk_i("midrst en_at", en1, 1);
        chk_i("midrst ready_at", en2, int'(LAT) + 2);
        chk("midrst if_rdata2", bus.if_rdata, 32'hCAFE_F00D);

        // Randomized traffic against the transaction-level model
        do_reset();
        e_en = -1; e_rdy = -1; idle_at = 0;
        e_f = 1'b0; e_we = 1'b0; last_f = 1'b0; f_busy = 1'b0; d_busy = 1'b0;
        e_addr = 32'h0; e_wdata = 32'h0; e_rdval = 32'h0;
        m_if = 32'h0; m_d = 32'h0; m_addr = 32'h0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            chk1("rnd mem_en", bus.mem_en, k == e_en);
            if (k == e_en) begin
                m_addr = e_addr;
                chk1("rnd mem_we", bus.mem_we, e_we);
                if (e_we) chk("rnd mem_wdata", bus.mem_wdata, e_wdata);
            end else begin
                chk1("rnd mem_we_idle", bus.mem_we, 1'b0);
            end
            chk("rnd mem_addr", bus.mem_addr, m_addr);
            if (k == e_rdy && !e_we) begin
                if (e_f) m_if = e_rdval;
                else     m_d  = e_rdval;
            end
            chk1("rnd if_ready", bus.if_ready, (k == e_rdy) && e_f);
            chk1("rnd d_ready", bus.d_ready, (k == e_rdy) && !e_f);
            chk("rnd if_rdata", bus.if_rdata, m_if);
            chk("rnd d_rdata", bus.d_rdata, m_d);
            if (k == e_rdy) begin
                if (e_f) f_busy = 1'b0;
                else     d_busy = 1'b0;
            end

            bus.if_req  = f_busy ? 1'b1 : 1'($urandom_range(0, 1));
            bus.if_addr = rand_addr();
            bus.d_req   = d_busy ? 1'b1 : 1'($urandom_range(0, 1));
            bus.d_addr  = rand_addr();
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_wdata = $urandom;
            if ($urandom_range(0, 7) == 0) halted = ~halted;

            if (k >= idle_at && ((bus.if_req && !halted) || bus.d_req)) begin
                e_f     = bus.if_req && !halted && (!bus.d_req || !last_f);
                e_we    = e_f ? 1'b0 : bus.d_we;
                e_addr  = e_f ? bus.if_addr : bus.d_addr;
                e_wdata = bus.d_wdata;
                e_en    = k + 1;
                e_rdy   = k + (e_we ? 2 : int'(LAT) + 2);
                idle_at = e_rdy + 1;
                last_f  = e_f;
                if (e_we) ref_mem[e_addr] = e_wdata;
                else      e_rdval = ref_rd(e_addr);
                if (e_f) f_busy = 1'b1;
                else     d_busy = 1'b1;
            end
        end
        drop_all();
        halted = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
